// File: rtl/pipeline_param_pkg.sv
// Shared constants and instruction field helpers for the parametrised
// ID/EX/WB ALU pipeline and its scoreboard.
package pipeline_param_pkg;

  // Opcodes
  localparam logic [1:0] OP_LI  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Scoreboard entry encodings: bit 1 = producer in EX, bit 0 = producer in WB
  localparam logic [1:0] SB_NONE = 2'b00;
  localparam logic [1:0] SB_WB   = 2'b01;
  localparam logic [1:0] SB_EX   = 2'b10;
  localparam logic [1:0] SB_EXWB = 2'b11;

  // Upper bound on register-index width the field helpers support
  localparam int MAX_RW     = 8;
  localparam int MAX_INST_W = 2 + 3 * MAX_RW;

  typedef logic [MAX_INST_W-1:0] inst_wide_t;
  typedef logic [MAX_RW-1:0]     field_wide_t;

  // Mask covering the low rw bits of a register-index field
  function automatic field_wide_t field_mask(input int unsigned rw);
    return field_wide_t'((32'd1 << rw) - 32'd1);
  endfunction

  // inst layout: {op[1:0], rs1[rw-1:0], rs2[rw-1:0], rd[rw-1:0]}
  function automatic logic [1:0] inst_op(input inst_wide_t inst, input int unsigned rw);
    inst_wide_t s;
    s = inst >> (3 * rw);
    return s[1:0];
  endfunction

  function automatic field_wide_t inst_rs1(input inst_wide_t inst, input int unsigned rw);
    inst_wide_t s;
    s = inst >> (2 * rw);
    return s[MAX_RW-1:0] & field_mask(rw);
  endfunction

  function automatic field_wide_t inst_rs2(input inst_wide_t inst, input int unsigned rw);
    inst_wide_t s;
    s = inst >> rw;
    return s[MAX_RW-1:0] & field_mask(rw);
  endfunction

  function automatic field_wide_t inst_rd(input inst_wide_t inst, input int unsigned rw);
    return inst[MAX_RW-1:0] & field_mask(rw);
  endfunction

  // LI carries an immediate in the source fields; every other opcode reads rs1/rs2
  function automatic logic op_uses_src(input logic [1:0] op);
    return op != OP_LI;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard.sv
// Per-register in-flight tracker. Each entry is a 2-bit shift register:
// bit 1 marks a producer currently in EX, bit 0 a producer currently in WB.
// Also reports where each source operand's latest producer sits and whether
// an instruction with those sources must wait (interlock mode).
module pipeline_scoreboard #(
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            accept,
  input  logic [RW-1:0]   rd,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  input  logic            uses_src,
  output logic [2*NREG-1:0] sb,
  output logic [1:0]      rs1_stage,
  output logic [1:0]      rs2_stage,
  output logic            stall
);
  import pipeline_param_pkg::*;

  logic [2*NREG-1:0] sb_q;
  logic [2*NREG-1:0] sb_d;

  // Advance every entry one stage; the accepted destination re-enters at EX
  always_comb begin
    sb_d = '0;
    for (int i = 0; i < NREG; i++) begin
      sb_d[2*i+1] = accept && (rd == RW'(i));
      sb_d[2*i]   = sb_q[2*i+1];
    end
  end

  // Scoreboard state, cleared by reset so nothing in flight survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Look up the pipeline position of each source's most recent producer
  always_comb begin
    rs1_stage = SB_NONE;
    rs2_stage = SB_NONE;
    for (int i = 0; i < NREG; i++) begin
      if (rs1 == RW'(i)) rs1_stage = sb_q[2*i +: 2];
      if (rs2 == RW'(i)) rs2_stage = sb_q[2*i +: 2];
    end
  end

  // Any pending producer of a used source blocks issue when not forwarding
  assign stall = uses_src && ((rs1_stage != SB_NONE) || (rs2_stage != SB_NONE));
  assign sb    = sb_q;

endmodule

// File: rtl/pipeline_param_v.sv
// Parametrised 3-stage (ID/EX/WB) ALU pipeline with a scoreboard.
// FWD_EN=1 forwards EX and WB results into ID and never stalls;
// FWD_EN=0 reads only the register file and interlocks on RAW hazards.
module pipeline_param_v #(
  parameter  int DATA_W = 8,
  parameter  int NREG   = 4,
  parameter  int FWD_EN = 1,
  parameter  int CNT_W  = 16,
  localparam int RW     = $clog2(NREG),
  localparam int INST_W = 2 + 3 * RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [RW-1:0]     dbg_rd_idx,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic [2*NREG-1:0] sb_stage,
  output logic [RW-1:0]     id_ex_rd,
  output logic              id_ex_reg_wen,
  output logic [RW-1:0]     ex_wb_rd,
  output logic              ex_wb_reg_wen,
  output logic [DATA_W-1:0] ex_wb_val,
  output logic [CNT_W-1:0]  retire_cnt
);
  import pipeline_param_pkg::*;

  // ---------------------------------------------------------------------
  // Instruction handshake: an instruction transfers on a rising edge where
  // inst_valid && inst_ready. The source keeps inst/inst_valid stable while
  // inst_valid is high and inst_ready is low. inst_ready does not depend on
  // inst_valid, and is low whenever rst is asserted.
  // ---------------------------------------------------------------------

  // Decoded ID-stage fields
  inst_wide_t          inst_w;
  logic [1:0]          op_s;
  logic [RW-1:0]       rs1_s;
  logic [RW-1:0]       rs2_s;
  logic [RW-1:0]       rd_s;
  logic                uses_src;
  logic [DATA_W-1:0]   imm_s;

  assign inst_w   = inst_wide_t'(inst);
  assign op_s     = inst_op(inst_w, RW);
  assign rs1_s    = RW'(inst_rs1(inst_w, RW));
  assign rs2_s    = RW'(inst_rs2(inst_w, RW));
  assign rd_s     = RW'(inst_rd(inst_w, RW));
  assign uses_src = op_use_src_w();
  // The {rs1,rs2} immediate is zero-extended, or truncated when wider than DATA_W
  assign imm_s    = DATA_W'({rs1_s, rs2_s});

  function automatic logic op_use_src_w();
    return op_uses_src(op_s);
  endfunction

  // Scoreboard
  logic       accept;
  logic       stall;
  logic [1:0] rs1_stage;
  logic [1:0] rs2_stage;

  assign inst_ready = rst & ((FWD_EN != 0) | ~stall);
  assign accept     = inst_valid & inst_ready;

  pipeline_scoreboard #(
    .NREG (NREG),
    .RW   (RW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst),
    .accept    (accept),
    .rd        (rd_s),
    .rs1       (rs1_s),
    .rs2       (rs2_s),
    .uses_src  (uses_src),
    .sb        (sb_stage),
    .rs1_stage (rs1_stage),
    .rs2_stage (rs2_stage),
    .stall     (stall)
  );

  // Pipeline and architectural state
  logic [1:0]        id_ex_op_q,   id_ex_op_d;
  logic [DATA_W-1:0] id_ex_a_q,    id_ex_a_d;
  logic [DATA_W-1:0] id_ex_b_q,    id_ex_b_d;
  logic [RW-1:0]     id_ex_rd_q,   id_ex_rd_d;
  logic              id_ex_wen_q,  id_ex_wen_d;
  logic [RW-1:0]     ex_wb_rd_q,   ex_wb_rd_d;
  logic              ex_wb_wen_q,  ex_wb_wen_d;
  logic [DATA_W-1:0] ex_wb_val_q,  ex_wb_val_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  // Operand fetch: newest producer wins (EX over WB over register file)
  always_comb begin
    opnd_a = regs_q[rs1_s];
    opnd_b = regs_q[rs2_s];
    if (FWD_EN != 0) begin
      if (rs1_stage[1])            opnd_a = ex_alu_result;
      else if (rs1_stage == SB_WB) opnd_a = ex_wb_val_q;
      if (rs2_stage[1])            opnd_b = ex_alu_result;
      else if (rs2_stage == SB_WB) opnd_b = ex_wb_val_q;
    end
  end

  // ID/EX load: accepted instruction or a bubble (write enable cleared)
  always_comb begin
    id_ex_op_d  = id_ex_op_q;
    id_ex_a_d   = id_ex_a_q;
    id_ex_b_d   = id_ex_b_q;
    id_ex_rd_d  = id_ex_rd_q;
    id_ex_wen_d = 1'b0;
    if (accept) begin
      id_ex_op_d  = op_s;
      id_ex_rd_d  = rd_s;
      id_ex_wen_d = 1'b1;
      if (op_s == OP_LI) begin
        id_ex_a_d = imm_s;
        id_ex_b_d = '0;
      end else begin
        id_ex_a_d = opnd_a;
        id_ex_b_d = opnd_b;
      end
    end
  end

  // EX: ALU, defined for every opcode; LI passes its immediate through
  always_comb begin
    ex_alu_result = id_ex_a_q;
    case (id_ex_op_q)
      OP_LI:   ex_alu_result = id_ex_a_q;
      OP_ADD:  ex_alu_result = id_ex_a_q + id_ex_b_q;
      OP_SUB:  ex_alu_result = id_ex_a_q - id_ex_b_q;
      OP_AND:  ex_alu_result = id_ex_a_q & id_ex_b_q;
      default: ex_alu_result = id_ex_a_q;
    endcase
  end

  // EX/WB load, register-file write and retire counting
  always_comb begin
    ex_wb_wen_d  = id_ex_wen_q;
    ex_wb_rd_d   = id_ex_rd_q;
    ex_wb_val_d  = ex_alu_result;
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (ex_wb_wen_q) begin
      regs_d[ex_wb_rd_q] = ex_wb_val_q;
      retire_cnt_d       = retire_cnt_q + CNT_W'(1);
    end
  end

  // All state; reset discards in-flight work and leaves LI in ID/EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_op_q   <= OP_LI;
      id_ex_a_q    <= '0;
      id_ex_b_q    <= '0;
      id_ex_rd_q   <= '0;
      id_ex_wen_q  <= 1'b0;
      ex_wb_rd_q   <= '0;
      ex_wb_wen_q  <= 1'b0;
      ex_wb_val_q  <= '0;
      retire_cnt_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      id_ex_op_q   <= id_ex_op_d;
      id_ex_a_q    <= id_ex_a_d;
      id_ex_b_q    <= id_ex_b_d;
      id_ex_rd_q   <= id_ex_rd_d;
      id_ex_wen_q  <= id_ex_wen_d;
      ex_wb_rd_q   <= ex_wb_rd_d;
      ex_wb_wen_q  <= ex_wb_wen_d;
      ex_wb_val_q  <= ex_wb_val_d;
      retire_cnt_q <= retire_cnt_d;
      regs_q       <= regs_d;
    end
  end

  assign dbg_rd_data   = regs_q[dbg_rd_idx];
  assign id_ex_rd      = id_ex_rd_q;
  assign id_ex_reg_wen = id_ex_wen_q;
  assign ex_wb_rd      = ex_wb_rd_q;
  assign ex_wb_reg_wen = ex_wb_wen_q;
  assign ex_wb_val     = ex_wb_val_q;
  assign retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_param_v.sv
// Bench for pipeline_param_v: one forwarding and one interlocking instance,
// exercised in turn against an in-order ISA model plus a stage-occupancy model.
module tb_pipeline_param_v;
  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int CNT_W  = 16;
  localparam int RW     = 2;
  localparam int INST_W = 2 + 3 * RW;
  localparam int W      = RW + DATA_W;
  localparam int MOD    = 1 << DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [INST_W-1:0] inst_f, inst_s;
  logic              valid_f, valid_s, ready_f, ready_s;
  logic [RW-1:0]     dbg_idx;
  logic [DATA_W-1:0] dbg_f, dbg_s;
  logic [2*NREG-1:0] sb_f, sb_s;
  logic [RW-1:0]     iexrd_f, iexrd_s, exwbrd_f, exwbrd_s;
  logic              iexwen_f, iexwen_s, exwbwen_f, exwbwen_s;
  logic [DATA_W-1:0] exwbval_f, exwbval_s;
  logic [CNT_W-1:0]  ret_f, ret_s;

  pipeline_param_v #(.DATA_W(DATA_W), .NREG(NREG), .FWD_EN(1), .CNT_W(CNT_W)) u_fwd (
    .clk(clk), .rst(rst), .inst(inst_f), .inst_valid(valid_f), .inst_ready(ready_f),
    .dbg_rd_idx(dbg_idx), .dbg_rd_data(dbg_f), .sb_stage(sb_f),
    .id_ex_rd(iexrd_f), .id_ex_reg_wen(iexwen_f), .ex_wb_rd(exwbrd_f),
    .ex_wb_reg_wen(exwbwen_f), .ex_wb_val(exwbval_f), .retire_cnt(ret_f));

  pipeline_param_v #(.DATA_W(DATA_W), .NREG(NREG), .FWD_EN(0), .CNT_W(CNT_W)) u_stl (
    .clk(clk), .rst(rst), .inst(inst_s), .inst_valid(valid_s), .inst_ready(ready_s),
    .dbg_rd_idx(dbg_idx), .dbg_rd_data(dbg_s), .sb_stage(sb_s),
    .id_ex_rd(iexrd_s), .id_ex_reg_wen(iexwen_s), .ex_wb_rd(exwbrd_s),
    .ex_wb_reg_wen(exwbwen_s), .ex_wb_val(exwbval_s), .retire_cnt(ret_s));

  // Observed outputs of whichever instance is under test
  logic              sel_fwd;
  logic              o_ready, o_iexwen, o_exwbwen;
  logic [DATA_W-1:0] o_dbg, o_exwbval;
  logic [2*NREG-1:0] o_sb;
  logic [RW-1:0]     o_iexrd, o_exwbrd;
  logic [CNT_W-1:0]  o_ret;

  always_comb begin
    o_ready   = sel_fwd ? ready_f   : ready_s;
    o_dbg     = sel_fwd ? dbg_f     : dbg_s;
    o_sb      = sel_fwd ? sb_f      : sb_s;
    o_iexrd   = sel_fwd ? iexrd_f   : iexrd_s;
    o_iexwen  = sel_fwd ? iexwen_f  : iexwen_s;
    o_exwbrd  = sel_fwd ? exwbrd_f  : exwbrd_s;
    o_exwbwen = sel_fwd ? exwbwen_f : exwbwen_s;
    o_exwbval = sel_fwd ? exwbval_f : exwbval_s;
    o_ret     = sel_fwd ? ret_f     : ret_s;
  end

  // ---------------- scoreboard / reference model state ----------------
  int                checks = 0;
  int                errors = 0;
  logic              cur_valid;
  logic [INST_W-1:0] cur_inst;
  int                arch_regs [NREG];   // ISA state in issue order
  int                ret_regs  [NREG];   // state after completed writes
  int                ret_cnt;
  logic [W-1:0]      exp_q [$];          // {rd, value} of issued, not yet in WB
  logic              acc_h1, acc_h2;     // accepted one / two edges ago
  logic [RW-1:0]     rd_h1, rd_h2;
  logic              wb_v_m;
  logic [RW-1:0]     wb_rd_m;
  int                wb_val_m;
  logic [7:0]        wb_hist;
  logic [DATA_W-1:0] obs_wb_q [$];
  int                wrap_exp [6] = '{15, 30, 60, 120, 240, 224};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      arch_regs[i] = 0;
      ret_regs[i]  = 0;
    end
    ret_cnt = 0;
    exp_q.delete();
    acc_h1 = 1'b0; acc_h2 = 1'b0; rd_h1 = '0; rd_h2 = '0;
    wb_v_m = 1'b0; wb_rd_m = '0; wb_val_m = 0;
    wb_hist = '0;
    obs_wb_q.delete();
  endtask

  function automatic int isa(input int op, input int a, input int b, input int imm);
    case (op)
      0:       return imm % MOD;
      1:       return (a + b) % MOD;
      2:       return (a - b + MOD) % MOD;
      default: return a & b;
    endcase
  endfunction

  // ---------------- driver: one clock cycle with full checking ----------------
  task automatic cycle(output logic acc);
    int op, rs1, rs2, rd, res;
    logic ready_e, hazard;
    logic [2*NREG-1:0] sb_e;
    logic [W-1:0] item;
    op  = int'(cur_inst[INST_W-1 -: 2]);
    rs1 = int'(cur_inst[3*RW-1 -: RW]);
    rs2 = int'(cur_inst[2*RW-1 -: RW]);
    rd  = int'(cur_inst[RW-1:0]);
    dbg_idx = RW'($urandom_range(0, NREG - 1));
    if (sel_fwd) begin
      inst_f = cur_inst; valid_f = cur_valid; valid_s = 1'b0;
    end else begin
      inst_s = cur_inst; valid_s = cur_valid; valid_f = 1'b0;
    end
    #1;
    hazard = (acc_h1 && (int'(rd_h1) == rs1 || int'(rd_h1) == rs2)) ||
             (acc_h2 && (int'(rd_h2) == rs1 || int'(rd_h2) == rs2));
    ready_e = sel_fwd ? 1'b1 : !((op != 0) && hazard);
    chk("inst_ready", o_ready, ready_e);
    acc = cur_valid && ready_e;
    if (acc) begin
      res = isa(op, arch_regs[rs1], arch_regs[rs2], rs1 * NREG + rs2);
      arch_regs[rd] = res;
      exp_q.push_back({RW'(rd), DATA_W'(res)});
    end
    @(posedge clk);
    #1;
    if (wb_v_m) begin
      ret_regs[wb_rd_m] = wb_val_m;
      ret_cnt = (ret_cnt + 1) % (1 << CNT_W);
    end
    acc_h2 = acc_h1; rd_h2 = rd_h1;
    acc_h1 = acc;    rd_h1 = RW'(rd);
    wb_v_m = acc_h2;
    if (acc_h2 && exp_q.size() > 0) begin
      item     = exp_q.pop_front();
      wb_rd_m  = item[W-1 -: RW];
      wb_val_m = int'(item[DATA_W-1:0]);
    end
    sb_e = '0;
    for (int i = 0; i < NREG; i++) begin
      sb_e[2*i+1] = acc_h1 && (int'(rd_h1) == i);
      sb_e[2*i]   = acc_h2 && (int'(rd_h2) == i);
    end
    chk("sb_stage", o_sb, sb_e);
    chk("id_ex_reg_wen", o_iexwen, acc_h1);
    if (acc_h1) chk("id_ex_rd", o_iexrd, rd_h1);
    chk("ex_wb_reg_wen", o_exwbwen, wb_v_m);
    if (wb_v_m) begin
      chk("ex_wb_rd", o_exwbrd, wb_rd_m);
      chk("ex_wb_val", o_exwbval, wb_val_m);
    end
    chk("retire_cnt", o_ret, ret_cnt);
    chk("dbg_rd_data", o_dbg, ret_regs[dbg_idx]);
    wb_hist = {wb_hist[6:0], o_exwbwen};
    if (o_exwbwen) obs_wb_q.push_back(o_exwbval);
  endtask

  task automatic issue(input int op, input int rs1, input int rs2, input int rd, output int stalls);
    logic acc;
    acc = 1'b0;
    cur_inst  = {2'(op), RW'(rs1), RW'(rs2), RW'(rd)};
    cur_valid = 1'b1;
    stalls    = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(acc);
      if (acc) break;
      stalls++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL issue_timeout: observed=not accepted expected=accepted within 20 cycles");
    end
    cur_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    cur_valid = 1'b0;
    cur_inst  = '0;
    for (int k = 0; k < n; k++) cycle(acc);
  endtask

  task automatic read_reg(input int idx, input int exp, input string tag);
    dbg_idx = RW'(idx);
    #1;
    chk(tag, o_dbg, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_in_reset", o_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int st0, st1, st2, st3;
    logic acc;
    rst = 1'b0; valid_f = 1'b0; valid_s = 1'b0; inst_f = '0; inst_s = '0;
    dbg_idx = '0; sel_fwd = 1'b1; cur_valid = 1'b0; cur_inst = '0;
    model_reset();

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_f", ready_f, 1'b0);
    chk("rst_ready_s", ready_s, 1'b0);
    chk("rst_sb_f", sb_f, 0);
    chk("rst_sb_s", sb_s, 0);
    chk("rst_retire_f", ret_f, 0);
    chk("rst_retire_s", ret_s, 0);
    chk("rst_exwbwen_f", exwbwen_f, 1'b0);
    for (int i = 0; i < NREG; i++) begin
      dbg_idx = RW'(i);
      #1;
      chk("rst_reg_f", dbg_f, 0);
      chk("rst_reg_s", dbg_s, 0);
    end

    // Reset mid-stream right after LI r1,5 is accepted
    @(negedge clk);
    rst = 1'b1;
    issue(0, 1, 1, 1, st0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_sb", o_sb, 0);
    chk("midrst_idexwen", o_iexwen, 1'b0);
    chk("midrst_ready", o_ready, 1'b0);
    chk("midrst_retire", o_ret, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_exwbwen", o_exwbwen, 1'b0);
    read_reg(1, 0, "midrst_r1");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(3);
    read_reg(1, 0, "midrst_r1_after");
    chk("midrst_retire_after", o_ret, 0);

    // Dependent ADD, then SUB underflow and AND, on both hazard modes
    for (int s = 0; s < 2; s++) begin
      sel_fwd = (s == 0);
      pulse_reset();
      issue(0, 1, 1, 1, st0);   // LI r1,5
      issue(0, 0, 3, 2, st1);   // LI r2,3
      issue(1, 1, 2, 3, st2);   // ADD r3,r1,r2
      chk("li_stall0", st0, 0);
      chk("li_stall1", st1, 0);
      if (sel_fwd) begin
        chk("fwd_add_stalls", st2, 0);
      end else begin
        chk("stl_add_stalls", st2, 2);
        chk("stl_bubbles", wb_hist[2:0], 3'b100);
      end
      idle(2);
      read_reg(3, 8, "add_r3");
      chk("add_retire", o_ret, 3);

      issue(0, 0, 3, 1, st0);   // LI r1,3
      issue(0, 1, 1, 2, st1);   // LI r2,5
      issue(2, 1, 2, 3, st2);   // SUB r3,r1,r2
      issue(3, 3, 2, 0, st3);   // AND r0,r3,r2
      idle(2);
      read_reg(3, 254, "sub_r3");
      read_reg(0, 4, "and_r0");
      chk("subands_retire", o_ret, 7);
    end

    // Wrap-around accumulation with forwarding
    sel_fwd = 1'b1;
    pulse_reset();
    issue(0, 3, 3, 0, st0);     // LI r0,15
    for (int k = 0; k < 5; k++) issue(1, 0, 0, 0, st1);
    idle(2);
    chk("wrap_count", obs_wb_q.size(), 6);
    for (int k = 0; k < 6 && k < obs_wb_q.size(); k++) chk("wrap_val", obs_wb_q[k], wrap_exp[k]);
    read_reg(0, 224, "wrap_r0");

    // Random streams; a stalled instruction is held until accepted
    for (int s = 0; s < 2; s++) begin
      sel_fwd = (s == 0);
      pulse_reset();
      acc = 1'b1;
      for (int n = 0; n < 10000; n++) begin
        if (!(cur_valid && !acc)) begin
          cur_valid = ($urandom_range(0, 3) != 0);
          cur_inst  = INST_W'($urandom);
        end
        cycle(acc);
      end
      idle(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_param_v.md
Name: pipeline_param_v

Overview:
- Parametrised successor of the 4-register, 8-bit, 3-stage (ID/EX/WB) ALU pipeline with scoreboard forwarding.
- Generalised in data width and register count; adds a load-immediate opcode, a valid/ready instruction handshake, and a compile-time hazard mode (forwarding vs. interlock-stall).
- Exposes scoreboard and pipeline-register state as outputs for invariant checking in the verification wrapper.

Parameters:
- DATA_W, 8, datapath and register width (>=4).
- NREG, 4, architectural register count; power of two, >=2.
- FWD_EN, 1, 1 = EX/WB forwarding with no stalls; 0 = no forwarding, interlock stall on RAW hazard.
- CNT_W, 16, retire counter width.
- Derived: RW = $clog2(NREG); INST_W = 2 + 3*RW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst  in  INST_W  {op[1:0], rs1[RW-1:0], rs2[RW-1:0], rd[RW-1:0]}.
- inst_valid  in  1  inst is presented this cycle.
- inst_ready  out  1  ID stage accepts inst this cycle.
- dbg_rd_idx  in  RW  combinational register-file read index.
- dbg_rd_data  out  DATA_W  registers[dbg_rd_idx].
- sb_stage  out  2*NREG  scoreboard; bits [2i+1:2i] belong to register i.
- id_ex_rd  out  RW; id_ex_reg_wen  out  1; ex_wb_rd  out  RW; ex_wb_reg_wen  out  1; ex_wb_val  out  DATA_W: pipeline state.
- retire_cnt  out  CNT_W  count of register-file writes.

Behaviour:
- Opcodes:
  - 00 LI: rd <= zero-extend({rs1,rs2}).
  - 01 ADD: rd <= rs1+rs2.
  - 10 SUB: rd <= rs1-rs2.
  - 11 AND: rd <= rs1&rs2.
  - All results are modulo 2^DATA_W; no flags. If 2*RW > DATA_W, the LI immediate is truncated to its low bits.
- Accept = inst_valid && inst_ready. Every accepted instruction writes rd. A cycle with no accept injects a bubble (id_ex_reg_wen=0).
- Latency: accept at edge t; ID/EX register loaded at t; EX/WB at t+1; register file written at t+2. A write is visible on dbg_rd_data after t+2.
- Scoreboard, per register i, every edge:
  - nxt = {1'b0, sb[i][1]}.
  - If accept && rd==i, sb[i] <= nxt|2'b10; otherwise sb[i] <= nxt.
  - Invariants the wrapper checks:
    - sb[i][1] <-> (id_ex_reg_wen && id_ex_rd==i).
    - sb[i][0] <-> (ex_wb_reg_wen && ex_wb_rd==i).
- Source operands: LI has none; ADD/SUB/AND use rs1 and rs2.
- FWD_EN=1:
  - inst_ready = 1 whenever out of reset.
  - Operand select per source: sb 1x -> ex_alu_result; 01 -> ex_wb_val; 00 -> register file.
  - The most recent producer always wins.
- FWD_EN=0:
  - inst_ready = 0 while any used source has sb != 00; no forwarding muxes.
  - A dependent instruction issued right after its producer stalls exactly 2 cycles.
  - inst is held by the source while stalled; a bubble enters EX each stall cycle.
- Write after write to the same rd in consecutive cycles: both write, in order; the last one wins. The scoreboard shows 11.
- retire_cnt increments on each edge where ex_wb_reg_wen=1; wraps to 0 at 2^CNT_W.
- Reset (rst low, any time, including mid-operation), immediate and asynchronous:
  - All registers, id_ex/ex_wb state, sb_stage, retire_cnt cleared to 0; id_ex op = LI.
  - inst_ready forced 0 while rst is low.
  - In-flight instructions are discarded; no write completes.
- No X-propagation: ex_alu_result is fully defined for all opcodes.

Decomposition:
- Package pipeline_param_pkg:
  - Opcode constants OP_LI/OP_ADD/OP_SUB/OP_AND.
  - Scoreboard encodings SB_NONE=00, SB_WB=01, SB_EX=10, SB_EXWB=11.
  - Field-extract functions parameterised by RW.
- Sub-module pipeline_scoreboard (NREG entries):
  - Inputs: accept, rd.
  - Outputs: sb vector, source stage lookups for rs1/rs2, stall signal (used when FWD_EN=0).

Test Plan:
1. Reset (NREG=4, DATA_W=8): pulse rst low mid-stream after LI r1,5 is accepted -> all dbg reads 0, sb_stage=0, retire_cnt=0, inst_ready=0 during reset; r1 stays 0.
2. FWD_EN=1: back-to-back LI r1,5; LI r2,3; ADD r3,r1,r2 -> inst_ready never drops; r3=8 two edges after the ADD accept; retire_cnt=3.
3. FWD_EN=0: same sequence -> inst_ready low exactly 2 cycles before the ADD is accepted; r3=8; two bubbles are visible as ex_wb_reg_wen=0.
4. Wrap: LI r0,15, then ADD r0,r0,r0 five times (FWD_EN=1) -> r0 = 30,60,120,240,224.
5. Underflow / AND: LI r1,3; LI r2,5; SUB r3,r1,r2 -> r3=254; AND r0,r3,r2 -> r0=4.
6. Invariants: random valid/inst streams for 10k cycles, both FWD_EN values -> scoreboard invariants hold every cycle; results match the ISA reference model.
